decoder_2x4_pipe: RTL and testbench

DECODER_2X4_PIPE -- requirements
Module: decoder_2x4_pipe

---
 rtl/decoder_pkg.sv | 29 ++
 rtl/decoder_2x4_comb.sv | 29 ++
 rtl/decoder_2x4_pipe.sv | 141 ++++++++++++++
 tb/tb_decoder_2x4_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared definitions for the 2-to-4 pipelined decoder:
//                occupancy FSM state encoding, one-hot code constants and
//                the default hit-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package decoder_pkg;

  // Occupancy of the two-entry (output + skid) storage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // One-hot words for each 2-bit code.
  localparam logic [3:0] Y_CODE0 = 4'b0001;
  localparam logic [3:0] Y_CODE1 = 4'b0010;
  localparam logic [3:0] Y_CODE2 = 4'b0100;
  localparam logic [3:0] Y_CODE3 = 4'b1000;
  localparam logic [3:0] Y_NONE  = 4'b0000;

  // Default width of each per-code hit counter.
  localparam int CNT_W_DEFAULT = 8;

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_2x4_comb.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_2x4_comb
//  Description : Purely combinational 2-to-4 one-hot decoder. Unknown or
//                out-of-range codes decode to all-zeros, so an X on the code
//                bus while it is not being used cannot leak a multi-hot word.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_2x4_comb
  import decoder_pkg::*;
(
  input  logic [1:0] code,
  output logic [3:0] y
);

  // Map each code to its one-hot word.
  always_comb begin
    y = Y_NONE;
    case (code)
      2'd0:    y = Y_CODE0;
      2'd1:    y = Y_CODE1;
      2'd2:    y = Y_CODE2;
      2'd3:    y = Y_CODE3;
      default: y = Y_NONE;
    endcase
  end

endmodule : decoder_2x4_comb
`default_nettype wire

// File: rtl/decoder_2x4_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_2x4_pipe
//  Description : Valid/ready pipelined 2-to-4 one-hot decoder. Codes are
//                decoded at the input and stored in an output register backed
//                by one skid register (two entries, FIFO order). in_ready and
//                out_valid are decoded from the state register only, so there
//                is no combinational path from out_ready to in_ready.
//                Optional macro DECODER_2X4_CNT_EN adds the hit_cnt port with
//                one wrapping CNT_W-bit acceptance counter per code.
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder_2x4_pipe
  import decoder_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       y
`ifdef DECODER_2X4_CNT_EN
  ,
  output logic [4*CNT_W-1:0] hit_cnt
`endif
);

  state_e     state_q, state_d;
  logic [3:0] y_q, y_d;
  logic [3:0] skid_q, skid_d;
  logic [3:0] dec_y;
  logic       in_xfer;
  logic       out_xfer;

  decoder_2x4_comb u_dec (
    .code (code),
    .y    (dec_y)
  );

  // Handshake flags are pure functions of the state register.
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  assign y = y_q;

  // Next-state and datapath steering for the two-entry storage.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          y_d     = dec_y;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          // Output word leaves and the new word replaces it in place.
          y_d     = dec_y;
          state_d = ONE;
        end else if (in_xfer) begin
          skid_d  = dec_y;
          state_d = TWO;
        end else if (out_xfer) begin
          y_d     = Y_NONE;
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain path exists.
        if (out_xfer) begin
          y_d     = skid_q;
          skid_d  = Y_NONE;
          state_d = ONE;
        end
      end
      default: begin
        y_d     = Y_NONE;
        skid_d  = Y_NONE;
        state_d = EMPTY;
      end
    endcase
  end

  // State and data registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      y_q     <= Y_NONE;
      skid_q  <= Y_NONE;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      skid_q  <= skid_d;
    end
  end

`ifdef DECODER_2X4_CNT_EN
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Bump the counter of the accepted code; natural overflow gives the wrap.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      if (in_xfer && (code == k[1:0])) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_hit_cnt
    assign hit_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`endif

endmodule : decoder_2x4_pipe
`default_nettype wire

// File: tb/tb_decoder_2x4_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder_2x4_pipe
//  Description : Self-checking bench for decoder_2x4_pipe: directed vector
//                table, asynchronous reset sequence, optional hit counter
//                sequence (DECODER_2X4_CNT_EN) and a random scoreboard run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_2x4_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] y;
`ifdef DECODER_2X4_CNT_EN
  logic [31:0] hit_cnt;
`endif

  decoder_2x4_pipe #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code      (code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef DECODER_2X4_CNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic       iv;
    logic [1:0] code;
    logic       ordy;
    logic       ov;
    logic       ir;
    logic [3:0] y;
  } vec_t;

  vec_t tbl [17];
  logic [3:0] exp_q [$];

  // Compare {out_valid, in_ready, y} against an expected packed value.
  task automatic check_out(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {out_valid, in_ready, y};
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got ov,ir,y=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One scoreboard cycle: drive, check pre-edge outputs against the model, update model.
  task automatic sb_cycle(input logic iv, input logic [1:0] c, input logic ordy);
    logic [3:0] head;
    @(negedge clk);
    in_valid  = iv;
    code      = iv ? c : 2'bxx;
    out_ready = ordy;
    #1;
    head = (exp_q.size() != 0) ? exp_q[0] : 4'b0000;
    vec_cnt++;
    if ((out_valid !== (exp_q.size() != 0)) || (in_ready !== (exp_q.size() < 2)) ||
        (out_valid && (y !== head)) || (out_valid && !$onehot(y))) begin
      err_cnt++;
      $display("FAIL scoreboard: got ov=%b ir=%b y=%b expected ov=%b ir=%b y=%b",
               out_valid, in_ready, y, (exp_q.size() != 0), (exp_q.size() < 2), head);
    end
    if (ordy && exp_q.size() != 0) void'(exp_q.pop_front());
    if (iv && exp_q.size() < 2 + (ordy && out_valid ? 1 : 0) && in_ready) exp_q.push_back(4'b0001 << c);
    @(posedge clk);
  endtask

  initial begin
    // in, code, out_ready  |  expected out_valid, in_ready, y after the edge
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0001};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b0010};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 4'b0100};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 4'b0100};
    tbl[6]  = '{1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[8]  = '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'b0010};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    tbl[12] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 4'b0001};
    tbl[13] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 4'b1000};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[15] = '{1'b0, 2'bxx, 1'b0, 1'b1, 1'b1, 4'b1000};
    tbl[16] = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    code      = 2'd0;
    out_ready = 1'b0;
    #2;
    check_out("reset_state", {1'b0, 1'b1, 4'b0000});
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      in_valid  = tbl[i].iv;
      code      = tbl[i].code;
      out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), {tbl[i].ov, tbl[i].ir, tbl[i].y});
    end

    // Asynchronous reset with both entries occupied.
    @(negedge clk);
    in_valid = 1'b1; code = 2'd1; out_ready = 1'b0;
    @(negedge clk);
    code = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_out("full_before_rst", {1'b1, 1'b0, 4'b0010});
    rst = 1'b1;
    #1;
    check_out("async_rst", {1'b0, 1'b1, 4'b0000});
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; code = 2'd2; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_out("after_rst_first", {1'b1, 1'b1, 4'b0100});
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_out("after_rst_drain", {1'b0, 1'b1, 4'b0000});

`ifdef DECODER_2X4_CNT_EN
    // 257 accepts of code 1: counter 1 wraps back to 1, others untouched.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("cnt_reset", hit_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; code = 2'd1; out_ready = 1'b1;
    repeat (257) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check_val("cnt_wrap", hit_cnt, 32'h0000_0100);
    @(negedge clk);
`endif

    // Random scoreboard run.
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    exp_q.delete();
    for (int n = 0; n < 1000; n++) begin
      sb_cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    for (int n = 0; n < 4; n++) begin
      sb_cycle(1'b0, 2'd0, 1'b1);
    end
    check_val("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_decoder_2x4_pipe
`default_nettype wire
